dcpu16_fmem: RTL and testbench
==============================

DCPU16_FMEM -- requirements
Module: dcpu16_fmem

Interface
REQ-001 Parameter AW, default 8, memory address width; array depth 2**AW words of 16 bits.
REQ-002 Parameter WAIT, default 1, wait states inserted before acknowledge; legal range 0..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 f_adr  input  16  word address from the fetch/bus master.
REQ-006 f_stb  input  1  request strobe; master holds it high until f_ack is seen.
REQ-007 f_wre  input  1  write enable; 1 = write, 0 = read; sampled with f_stb.
REQ-008 f_dto  input  16  write data from master; sampled with f_stb.
REQ-009 f_dti  output  16  read data to master; registered.
REQ-010 f_ack  output  1  single-cycle acknowledge; registered.

Function
REQ-011 The block SHALL be the responder end of the DCPU16 fetch bus, answering the request that the CPU control unit completes on f_ack/f_dti.
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-013 In IDLE with f_stb=1, the block SHALL latch f_adr, f_wre and f_dto, then enter ACK if WAIT=0, else load the 4-bit wait counter with WAIT-1 and enter WAIT.
REQ-014 In WAIT, the counter SHALL decrement each cycle; at count 0 the next state SHALL be ACK.
REQ-015 In WAIT, f_stb=0 SHALL abort the transaction: return to IDLE, no ack, no memory write.
REQ-016 In ACK, f_ack SHALL be 1 for exactly one cycle; the next state SHALL be IDLE regardless of f_stb.
REQ-017 Latency: request first sampled at edge N SHALL give f_ack=1 during cycle N+1+WAIT.
REQ-018 f_dti SHALL present mem[latched address] during the ACK cycle and hold its value until the next ACK or reset.
REQ-019 A write SHALL update mem[latched address] with latched f_dto on the edge entering ACK. On a write ACK, f_dti SHALL return the written value (write-first).
REQ-020 Out-of-range address (f_adr[15:AW] != 0) SHALL still be acknowledged with f_dti=16'h0000; a write to it SHALL be dropped.
REQ-021 With f_stb still high in IDLE after an ACK, the block SHALL treat it as a new request (back-to-back rate: one transaction per WAIT+2 cycles).
REQ-022 Address bits and data SHALL be used unsigned with no arithmetic; the wait counter SHALL never wrap below 0.

Reset
REQ-023 During rst=1: state IDLE, wait counter 0, f_ack=0, f_dti=16'h0000, latched address/data/wre cleared.
REQ-024 Reset SHALL NOT clear memory contents.
REQ-025 Reset asserted mid-transaction (WAIT or ACK) SHALL cancel it: no ack after reset, and no write unless it already occurred on the edge into ACK.
REQ-026 rst SHALL take priority over all other inputs on the same edge.

Verification
REQ-027 WAIT=1: write adr 16'h0010 data 16'hBEEF -> f_ack high in cycle N+2 only, f_dti=16'hBEEF; then read 16'h0010 -> f_ack at N+2, f_dti=16'hBEEF.
REQ-028 WAIT=0: read adr 16'h0003 preloaded with 16'h7C01, f_stb held high across three requests -> f_ack pulses every 2nd cycle, each f_dti=16'h7C01.
REQ-029 AW=8: write 16'h1234 to adr 16'h0100 -> acked, f_dti=16'h0000; read adr 16'h0000 -> original contents unchanged.
REQ-030 WAIT=3: write request with f_stb dropped one cycle after issue -> no f_ack within 10 cycles, target word unchanged, FSM back in IDLE.
REQ-031 WAIT=3: rst pulsed during WAIT -> f_ack=0 and f_dti=16'h0000 the cycle after reset; memory contents intact on subsequent read.
REQ-032 Reset during ACK of write 16'hA5A5 to adr 16'h0020 -> subsequent read of 16'h0020 returns 16'hA5A5.

Source files
------------

// File: rtl/dcpu16_fmem_if.sv
// DCPU16 fetch bus: one master request channel, one responder.
// Master holds f_stb until it sees the single-cycle f_ack.
interface dcpu16_fmem_if;
  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_wre;
  logic [15:0] f_dto;
  logic [15:0] f_dti;
  logic        f_ack;

  modport master (
    output f_adr, f_stb, f_wre, f_dto,
    input  f_dti, f_ack
  );

  modport slave (
    input  f_adr, f_stb, f_wre, f_dto,
    output f_dti, f_ack
  );
endinterface

// File: rtl/dcpu16_fmem.sv
// DCPU16 fetch-bus memory responder with programmable wait states.
// Single-port word memory; registered ack and read data.
module dcpu16_fmem #(
  parameter int AW   = 8,
  parameter int WAIT = 1
) (
  input logic          clk,
  input logic          rst,
  dcpu16_fmem_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [3:0] WLOAD =
    (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] adr_q;
  logic [15:0] dto_q;
  logic        wre_q;
  logic        ack_q;
  logic [15:0] dti_q;

  logic [15:0] mem [2**AW];

  logic        go_ack;
  logic        use_in;
  logic [15:0] adr_n;
  logic [15:0] dto_n;
  logic        wre_n;
  logic        in_rng;
  logic [15:0] rd_data;

  // With no wait states the request goes straight from IDLE to ACK,
  // so the live bus inputs must be used on that edge.
  always_comb begin
    go_ack  = 1'b0;
    use_in  = (state == S_IDLE);
    adr_n   = use_in ? bus.f_adr : adr_q;
    dto_n   = use_in ? bus.f_dto : dto_q;
    wre_n   = use_in ? bus.f_wre : wre_q;
    unique case (state)
      S_IDLE:  go_ack = bus.f_stb && (WAIT == 0);
      S_WAIT:  go_ack = bus.f_stb && (cnt == 4'd0);
      default: go_ack = 1'b0;
    endcase
    in_rng  = (adr_n >> AW) == 16'd0;
    rd_data = 16'h0000;
    if (in_rng)
      rd_data = wre_n ? dto_n : mem[adr_n[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst && go_ack && wre_n && in_rng)
      mem[adr_n[AW-1:0]] <= dto_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      adr_q <= 16'h0000;
      dto_q <= 16'h0000;
      wre_q <= 1'b0;
      ack_q <= 1'b0;
      dti_q <= 16'h0000;
    end else begin
      ack_q <= 1'b0;
      if (go_ack) begin
        ack_q <= 1'b1;
        dti_q <= rd_data;
      end
      unique case (state)
        S_IDLE: begin
          if (bus.f_stb) begin
            adr_q <= bus.f_adr;
            dto_q <= bus.f_dto;
            wre_q <= bus.f_wre;
            if (WAIT == 0) begin
              state <= S_ACK;
            end else begin
              cnt   <= WLOAD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.f_stb) begin
            cnt   <= 4'd0;
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.f_ack = ack_q;
  assign bus.f_dti = dti_q;

endmodule

// File: tb/tb_dcpu16_fmem.sv
// Directed bench for dcpu16_fmem: three instances with 1, 0 and 3
// wait states, driven from transaction tables and hand sequences.
module tb_dcpu16_fmem;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  stb;
  logic [2:0]  wre;
  logic [15:0] adr [3];
  logic [15:0] dto [3];
  logic [2:0]  ack;
  logic [15:0] dti [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcpu16_fmem_if b0 ();
  dcpu16_fmem_if b1 ();
  dcpu16_fmem_if b2 ();

  assign b0.f_stb = stb[0];
  assign b0.f_wre = wre[0];
  assign b0.f_adr = adr[0];
  assign b0.f_dto = dto[0];
  assign ack[0]   = b0.f_ack;
  assign dti[0]   = b0.f_dti;

  assign b1.f_stb = stb[1];
  assign b1.f_wre = wre[1];
  assign b1.f_adr = adr[1];
  assign b1.f_dto = dto[1];
  assign ack[1]   = b1.f_ack;
  assign dti[1]   = b1.f_dti;

  assign b2.f_stb = stb[2];
  assign b2.f_wre = wre[2];
  assign b2.f_adr = adr[2];
  assign b2.f_dto = dto[2];
  assign ack[2]   = b2.f_ack;
  assign dti[2]   = b2.f_dti;

  dcpu16_fmem #(.AW(8), .WAIT(1)) u_w1 (
    .clk(clk), .rst(rst[0]), .bus(b0)
  );
  dcpu16_fmem #(.AW(8), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst[1]), .bus(b1)
  );
  dcpu16_fmem #(.AW(8), .WAIT(3)) u_w3 (
    .clk(clk), .rst(rst[2]), .bus(b2)
  );

  typedef struct {
    int          d;
    int          w;
    logic        we;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request, expect ack after w+1 edges, then a 1-cycle pulse.
  task automatic xact(input int d, input int w,
                      input logic we, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp,
                      input string nm);
    int c;
    stb[d] = 1'b1;
    wre[d] = we;
    adr[d] = a;
    dto[d] = wd;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ack[d] && c < 20);
    stb[d] = 1'b0;
    wre[d] = 1'b0;
    chk({nm, " latency"}, 16'(c), 16'(w + 1));
    chk({nm, " dti"}, dti[d], exp);
    @(negedge clk);
    chk({nm, " ack pulse"}, {15'd0, ack[d]}, 16'd0);
    chk({nm, " dti hold"}, dti[d], exp);
  endtask

  initial begin
    rst = 3'b111;
    stb = 3'b000;
    wre = 3'b000;
    for (int i = 0; i < 3; i++) begin
      adr[i] = 16'h0000;
      dto[i] = 16'h0000;
    end

    vecs.push_back('{0, 1, 1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, "w1 wr 10"});
    vecs.push_back('{0, 1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "w1 rd 10"});
    vecs.push_back('{0, 1, 1'b1, 16'h0000, 16'h5555, 16'h5555, "w1 wr 00"});
    vecs.push_back('{0, 1, 1'b1, 16'h0100, 16'h1234, 16'h0000, "w1 wr oor"});
    vecs.push_back('{0, 1, 1'b0, 16'h0000, 16'h0000, 16'h5555, "w1 rd 00"});
    vecs.push_back('{0, 1, 1'b0, 16'h8000, 16'h0000, 16'h0000, "w1 rd oor"});
    vecs.push_back('{0, 1, 1'b1, 16'h00FF, 16'hCAFE, 16'hCAFE, "w1 wr ff"});
    vecs.push_back('{0, 1, 1'b0, 16'h00FF, 16'h0000, 16'hCAFE, "w1 rd ff"});
    vecs.push_back('{0, 1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "w1 rd 10b"});
    vecs.push_back('{2, 3, 1'b1, 16'h0030, 16'h1111, 16'h1111, "w3 wr 30"});
    vecs.push_back('{2, 3, 1'b0, 16'h0030, 16'h0000, 16'h1111, "w3 rd 30"});

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst ack %0d", i), {15'd0, ack[i]}, 16'd0);
      chk($sformatf("rst dti %0d", i), dti[i], 16'h0000);
    end
    rst = 3'b000;
    @(negedge clk);

    foreach (vecs[i])
      xact(vecs[i].d, vecs[i].w, vecs[i].we, vecs[i].a,
           vecs[i].wd, vecs[i].exp, vecs[i].name);

    // WAIT=0 back-to-back reads with strobe held high
    xact(1, 0, 1'b1, 16'h0003, 16'h7C01, 16'h7C01, "w0 wr 03");
    stb[1] = 1'b1;
    wre[1] = 1'b0;
    adr[1] = 16'h0003;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) stb[1] = 1'b0;
      chk($sformatf("w0 b2b ack %0d", i), {15'd0, ack[1]},
          (i % 2 == 0) ? 16'd1 : 16'd0);
      chk($sformatf("w0 b2b dti %0d", i), dti[1], 16'h7C01);
    end

    // WAIT=3 write aborted one cycle after issue
    stb[2] = 1'b1;
    wre[2] = 1'b1;
    adr[2] = 16'h0030;
    dto[2] = 16'h2222;
    @(negedge clk);
    stb[2] = 1'b0;
    wre[2] = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ack[2]) seen++;
      end
      chk("w3 abort no ack", 16'(seen), 16'd0);
    end
    xact(2, 3, 1'b0, 16'h0030, 16'h0000, 16'h1111, "w3 rd after abort");

    // WAIT=3 reset during WAIT cancels the write
    stb[2] = 1'b1;
    wre[2] = 1'b1;
    adr[2] = 16'h0030;
    dto[2] = 16'h3333;
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    stb[2] = 1'b0;
    wre[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("w3 rst wait ack", {15'd0, ack[2]}, 16'd0);
    chk("w3 rst wait dti", dti[2], 16'h0000);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (ack[2]) seen++;
      end
      chk("w3 rst wait no late ack", 16'(seen), 16'd0);
    end
    xact(2, 3, 1'b0, 16'h0030, 16'h0000, 16'h1111, "w3 rd after rst");

    // WAIT=3 reset during ACK keeps the write already done
    stb[2] = 1'b1;
    wre[2] = 1'b1;
    adr[2] = 16'h0020;
    dto[2] = 16'hA5A5;
    begin
      int c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!ack[2] && c < 20);
      chk("w3 rst ack latency", 16'(c), 16'd4);
    end
    rst[2] = 1'b1;
    stb[2] = 1'b0;
    wre[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("w3 rst ack ack", {15'd0, ack[2]}, 16'd0);
    chk("w3 rst ack dti", dti[2], 16'h0000);
    @(negedge clk);
    xact(2, 3, 1'b0, 16'h0020, 16'h0000, 16'hA5A5, "w3 rd 20");
    xact(2, 3, 1'b0, 16'h0030, 16'h0000, 16'h1111, "w3 rd 30 end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
